// File: rtl/vga_pkg.sv
// Default 640x480@60 raster timing, shared by the timing generator and the renderers.
package vga_pkg;

   localparam int H_VISIBLE = 640;
   localparam int H_FRONT   = 16;
   localparam int H_SYNC    = 96;
   localparam int H_BACK    = 48;
   localparam int H_TOTAL   = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;

   localparam int V_VISIBLE = 480;
   localparam int V_FRONT   = 10;
   localparam int V_SYNC    = 2;
   localparam int V_BACK    = 33;
   localparam int V_TOTAL   = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

   // Idle value of the {hs, vs, blank} sideband: syncs inactive, pixel dark.
   localparam logic [2:0] SYNC_IDLE = 3'b110;

endpackage

// File: rtl/sync_delay_line.sv
// Fixed-depth shift register with a reset value; aligns sideband signals
// with a pipelined datapath. DEPTH of 0 is a plain wire.
module sync_delay_line #(
   parameter int                WIDTH   = 3,
   parameter int                DEPTH   = 2,
   parameter logic [WIDTH-1:0]  RST_VAL = '0
) (
   input  logic             vga_clk,
   input  logic             reset_n,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout
);

   if (DEPTH == 0) begin : g_pass
      assign dout = din;
   end else begin : g_pipe
      logic [WIDTH-1:0] stage_q [DEPTH];

      always_ff @(posedge vga_clk) begin
         if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) stage_q[i] <= RST_VAL;
         end else begin
            stage_q[0] <= din;
            for (int i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
         end
      end

      assign dout = stage_q[DEPTH-1];
   end

endmodule

// File: rtl/vga_timing_gen.sv
// Free-running raster counter with undelayed pixel position/blank for the
// renderers and pipeline-aligned HS/VS/blank for the monitor side.
module vga_timing_gen
   import vga_pkg::*;
#(
   parameter int H_VISIBLE = vga_pkg::H_VISIBLE,
   parameter int H_FRONT   = vga_pkg::H_FRONT,
   parameter int H_SYNC    = vga_pkg::H_SYNC,
   parameter int H_BACK    = vga_pkg::H_BACK,
   parameter int V_VISIBLE = vga_pkg::V_VISIBLE,
   parameter int V_FRONT   = vga_pkg::V_FRONT,
   parameter int V_SYNC    = vga_pkg::V_SYNC,
   parameter int V_BACK    = vga_pkg::V_BACK,
   parameter int PIPE_DLY  = 2
) (
   input  logic       vga_clk,
   input  logic       reset_n,
   output logic [9:0] DrawX,
   output logic [9:0] DrawY,
   output logic       blank,
   output logic       hs,
   output logic       vs,
   output logic       blank_d,
   output logic       line_end,
   output logic       frame_end,
   output logic [7:0] frame_count
);

   localparam int H_TOT = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
   localparam int V_TOT = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

   localparam logic [9:0] H_VIS_LIM = 10'(H_VISIBLE);
   localparam logic [9:0] H_LAST    = 10'(H_TOT - 1);
   localparam logic [9:0] HS_START  = 10'(H_VISIBLE + H_FRONT);
   localparam logic [9:0] HS_END    = 10'(H_VISIBLE + H_FRONT + H_SYNC);
   localparam logic [9:0] V_VIS_LIM = 10'(V_VISIBLE);
   localparam logic [9:0] V_LAST    = 10'(V_TOT - 1);
   localparam logic [9:0] VS_START  = 10'(V_VISIBLE + V_FRONT);
   localparam logic [9:0] VS_END    = 10'(V_VISIBLE + V_FRONT + V_SYNC);

   logic [9:0] hc, vc;
   logic [9:0] hc_nxt, vc_nxt;
   logic       frame_end_nxt;
   logic       hs_raw, vs_raw;
   logic [2:0] sync_dly;

   always_comb begin
      hc_nxt = hc + 10'd1;
      vc_nxt = vc;
      if (hc == H_LAST) begin
         hc_nxt = '0;
         vc_nxt = (vc == V_LAST) ? '0 : vc + 10'd1;
      end
   end

   assign frame_end_nxt = (hc_nxt == H_LAST) && (vc_nxt == V_LAST);

   // Flags are loaded from the next-state counts so they change with DrawX/DrawY.
   always_ff @(posedge vga_clk) begin
      if (!reset_n) begin
         hc          <= '0;
         vc          <= '0;
         blank       <= 1'b1;
         line_end    <= 1'b0;
         frame_end   <= 1'b0;
         frame_count <= '0;
      end else begin
         hc        <= hc_nxt;
         vc        <= vc_nxt;
         blank     <= (hc_nxt < H_VIS_LIM) && (vc_nxt < V_VIS_LIM);
         line_end  <= (hc_nxt == H_LAST);
         frame_end <= frame_end_nxt;
         if (frame_end_nxt) frame_count <= frame_count + 8'd1;
      end
   end

   assign hs_raw = !((hc >= HS_START) && (hc < HS_END));
   assign vs_raw = !((vc >= VS_START) && (vc < VS_END));

   sync_delay_line #(
      .WIDTH   (3),
      .DEPTH   (PIPE_DLY),
      .RST_VAL (SYNC_IDLE)
   ) u_sync_dly (
      .vga_clk (vga_clk),
      .reset_n (reset_n),
      .din     ({hs_raw, vs_raw, blank}),
      .dout    (sync_dly)
   );

   assign {hs, vs, blank_d} = sync_dly;
   assign DrawX = hc;
   assign DrawY = vc;

endmodule
